// File: rtl/rr_arbiter_8_pkg.sv
//==============================================================================
// Package : arb_pkg
// Brief   : Shared sizes, FSM encoding and hold-limit default for rr_arbiter_8.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package arb_pkg;
  localparam int N            = 8;
  localparam int IDXW         = 3;
  localparam int MAX_HOLD_DEF = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter_8_if.sv
//==============================================================================
// Interface : rr_arbiter_8_if
// Brief     : Request/grant bundle between requesters and the arbiter.
// Rev       : 1.0  initial release
//==============================================================================
`default_nettype none

interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_8_enc.sv
//==============================================================================
// Module : onehot_enc_8_to_3
// Brief  : Combinational one-hot to binary index encoder (zero in -> zero out).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module onehot_enc_8_to_3
  import arb_pkg::*;
(
  input  logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | i[IDXW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
//==============================================================================
// Module : rr_arbiter_8
// Brief  : 8-way round-robin arbiter, registered one-hot + index grant, grant
//          held until the owner releases. Optional macro HOLD_TIMEOUT_EN adds
//          a MAX_HOLD-cycle preemption limit when others are waiting.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [0:0]      r_state;
    logic [IDXW-1:0] r_ptr;
    logic [N-1:0]    r_gnt;
    logic [IDXW-1:0] r_idx;
    logic            r_valid;
`ifdef HOLD_TIMEOUT_EN
    logic [7:0]      r_cnt;
`endif

    logic [IDXW-1:0] w_start;
    logic [N-1:0]    w_cand;
    logic [N-1:0]    w_rot;
    logic [IDXW-1:0] w_off;
    logic            w_found;
    logic [IDXW-1:0] w_win;
    logic            w_take;
    logic            w_new;
    logic            w_drop;
    logic [N-1:0]    w_gnt_nxt;
    logic [IDXW-1:0] w_idx_nxt;

    // Rotating search: rotate candidates so bit 0 is w_start, pick first set.
    always_comb begin
        w_rot   = N'({w_cand, w_cand} >> w_start);
        w_found = |w_rot;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = i[IDXW-1:0];
        end
        w_win = w_start + w_off;
    end

    always_comb begin
        w_start = r_ptr;
        w_cand  = req;
        w_take  = 1'b0;
        w_drop  = 1'b0;
        if (r_state == ST_IDLE) begin
            w_take = |req;
        end else begin
            // Owner excluded; on release its req bit is already zero anyway.
            w_start = r_idx + 3'd1;
            w_cand  = req & ~r_gnt;
            if (!(|(req & r_gnt))) begin
                w_take = 1'b1;
                w_drop = ~(|w_cand);
            end
`ifdef HOLD_TIMEOUT_EN
            else if ((r_cnt >= 8'(MAX_HOLD - 1)) && (|w_cand)) begin
                w_take = 1'b1;
            end
`endif
        end
        w_new = w_take & w_found;
        if (w_new)       w_gnt_nxt = N'(1) << w_win;
        else if (w_drop) w_gnt_nxt = '0;
        else             w_gnt_nxt = r_gnt;
    end

    onehot_enc_8_to_3 u_enc (
        .onehot (w_gnt_nxt),
        .idx    (w_idx_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= (|w_gnt_nxt) ? ST_GRANT : ST_IDLE;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= |w_gnt_nxt;
            if (w_new) r_ptr <= w_win + 3'd1;
        end
    end

`ifdef HOLD_TIMEOUT_EN
    // Saturates at the limit so a late-arriving competitor still preempts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_new) begin
            r_cnt <= '0;
        end else if ((r_state == ST_GRANT) && (r_cnt < 8'(MAX_HOLD - 1))) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
//==============================================================================
// Module : tb_rr_arbiter_8
// Brief  : Directed self-checking bench for rr_arbiter_8.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_rr_arbiter_8;
    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  gnt;
    logic [2:0]  gnt_idx;
    logic        gnt_valid;
    int          checks;
    int          errors;
    logic [11:0] got;
    logic [11:0] exp;

    rr_arbiter_8 #(.MAX_HOLD(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quick_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        req = 8'h00;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        step();
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'h00, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_hold gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        rst_n = 1'b1;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'h01, 3'd0, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_release gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        req = 8'h00;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'h00, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_idle gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic test_single();
        req = 8'b0010_0000;
        for (int c = 0; c < 11; c++) begin
            step();
            got = {gnt, gnt_idx, gnt_valid};
            exp = {8'b0010_0000, 3'd5, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_hold c=%0d gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                         c, got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
            end
        end
        req = 8'h00;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'h00, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_drop gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
    endtask

    // Pointer sits at 6 here; granting 6 moves it to 7, so 0 must beat 6.
    task automatic test_wrap();
        req = 8'b0100_0000;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'b0100_0000, 3'd6, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_grant6 gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        req = 8'h00;
        step();
        req = 8'b0100_0001;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'b0000_0001, 3'd0, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_ptr gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_async_reset();
        req = 8'b0000_1000;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'b0000_1000, 3'd3, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_pre gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'h00, 3'd0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_drop gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        req = 8'b1000_1000;
        #1 rst_n = 1'b1;
        step();
        got = {gnt, gnt_idx, gnt_valid};
        exp = {8'b0000_1000, 3'd3, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_restart gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                     got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        logic [7:0] one;
        quick_reset();
        req = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            step();
            one = 8'b1 << (i % 8);
            got = {gnt, gnt_idx, gnt_valid};
            exp = {one, 3'(i % 8), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rotation i=%0d gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                         i, got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
            end
            req = ~one;
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_hold_timeout();
        logic [2:0] e_idx;
        quick_reset();
        req = 8'b0010_0100;
        for (int e = 0; e < 9; e++) begin
            step();
`ifdef HOLD_TIMEOUT_EN
            e_idx = (((e / 4) % 2) == 0) ? 3'd2 : 3'd5;
`else
            e_idx = 3'd2;
`endif
            got = {gnt, gnt_idx, gnt_valid};
            exp = {8'b1 << e_idx, e_idx, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold e=%0d gnt=%h idx=%0d v=%b exp gnt=%h idx=%0d v=%b",
                         e, got[11:4], got[3:1], got[0], exp[11:4], exp[3:1], exp[0]);
            end
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        test_reset();
        test_single();
        test_wrap();
        test_async_reset();
        test_rotation();
        test_hold_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
